// File: rtl/gf_pkg.sv
// Shared definitions for the GF(2^m) arithmetic blocks: field limits,
// example reduction polynomials, FSM state type and the operand mask helper.
package gf_pkg;

  localparam int unsigned GF_WIDTH = 4;

  localparam logic [4:0] POLY_M3 = 5'b01011;  // x^3 + x + 1
  localparam logic [4:0] POLY_M4 = 5'b11001;  // x^4 + x^3 + 1

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SQ   = 2'd1,
    MUL  = 2'd2
  } state_t;

  // Low m bits set; bits at or above the field degree are cleared.
  function automatic logic [GF_WIDTH-1:0] mask(input logic [2:0] m);
    logic [GF_WIDTH-1:0] r;
    r = '0;
    for (int unsigned j = 0; j < GF_WIDTH; j++) begin
      r[j] = (3'(j) < m);
    end
    return r;
  endfunction

endpackage

// File: rtl/gfmul2.sv
// Combinational GF(2^m) multiplier with runtime field select (m, p).
// Operands are expected to be already reduced below x^m.
module gfmul2
  import gf_pkg::*;
#(
  parameter int unsigned WIDTH = GF_WIDTH
) (
  input  logic [2:0]       m,
  input  logic [4:0]       p,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] mul
);

  logic [WIDTH:0] acc;
  logic           top;

  // MSB-first shift-and-add; reduce whenever the x^m term appears after a shift.
  always_comb begin
    acc = '0;
    top = 1'b0;
    for (int unsigned k = 0; k < WIDTH; k++) begin
      acc = {acc[WIDTH-1:0], 1'b0};
      top = 1'b0;
      for (int unsigned j = 0; j <= WIDTH; j++) begin
        if (m == 3'(j)) top = acc[j];
      end
      if (top) acc = acc ^ (WIDTH+1)'(p);
      if (b[WIDTH-1-k]) acc = acc ^ {1'b0, a};
    end
    mul = acc[WIDTH-1:0];
  end

endmodule

// File: rtl/gf_inverse_seq.sv
// Sequential GF(2^m) inverter: inv = a^(2^m-2), built by alternating a
// squaring step and an accumulate-multiply step through one shared gfmul2.
module gf_inverse_seq
  import gf_pkg::*;
#(
  parameter int unsigned WIDTH = GF_WIDTH,
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [2:0]       m,
  input  logic [4:0]       p,
  input  logic [WIDTH-1:0] a,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] inv,
  output logic             err
);

  state_t           state;
  logic [WIDTH-1:0] sq;
  logic [WIDTH-1:0] r;
  logic [CNT_W-1:0] cnt;
  logic [2:0]       m_q;
  logic [4:0]       p_q;

  logic [WIDTH-1:0] a_m;
  logic [WIDTH-1:0] mask_q;
  logic [WIDTH-1:0] op_a;
  logic [WIDTH-1:0] op_b;
  logic [WIDTH-1:0] mul;
  logic             legal;

  assign a_m    = a & WIDTH'(mask(m));
  assign mask_q = WIDTH'(mask(m_q));
  assign legal  = (m >= 3'd2) && (32'(m) <= WIDTH);

  always_comb begin
    op_a = '0;
    op_b = '0;
    case (state)
      SQ: begin
        op_a = sq & mask_q;
        op_b = sq & mask_q;
      end
      MUL: begin
        op_a = r & mask_q;
        op_b = sq & mask_q;
      end
      default: ;
    endcase
  end

  gfmul2 #(.WIDTH(WIDTH)) u_mul (
    .m   (m_q),
    .p   (p_q),
    .a   (op_a),
    .b   (op_b),
    .mul (mul)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      sq    <= '0;
      r     <= '0;
      cnt   <= '0;
      m_q   <= '0;
      p_q   <= '0;
      busy  <= 1'b0;
      done  <= 1'b0;
      inv   <= '0;
      err   <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            m_q <= m;
            p_q <= p;
            if (legal && (a_m != '0)) begin
              sq    <= a_m;
              r     <= WIDTH'(1);
              cnt   <= CNT_W'(m - 3'd1);
              busy  <= 1'b1;
              state <= SQ;
            end else begin
              done <= 1'b1;
              err  <= 1'b1;
              inv  <= '0;
            end
          end
        end
        SQ: begin
          sq    <= mul;
          state <= MUL;
        end
        MUL: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt != CNT_W'(1)) begin
            r     <= mul;
            state <= SQ;
          end else begin
            inv   <= mul;
            done  <= 1'b1;
            err   <= 1'b0;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_gf_inverse_seq.sv
// Scoreboard bench for gf_inverse_seq: the driver queues expected results,
// a negedge monitor pops and compares them whenever done is seen.
module tb_gf_inverse_seq;
  import gf_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       start = 1'b0;
  logic [2:0] m = '0;
  logic [4:0] p = '0;
  logic [3:0] a = '0;
  logic       busy, done, err;
  logic [3:0] inv;

  gf_inverse_seq #(.WIDTH(4), .CNT_W(3)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .m     (m),
    .p     (p),
    .a     (a),
    .busy  (busy),
    .done  (done),
    .inv   (inv),
    .err   (err)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] inv;
    logic       err;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   n_vec  = 0;
  int   n_bad  = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference: full carry-less product, then long-division reduction.
  function automatic logic [3:0] ref_mul(input int mm, input logic [4:0] pp,
                                         input logic [3:0] x, input logic [3:0] y);
    logic [7:0] pr;
    logic [7:0] pl;
    pr = '0;
    for (int i = 0; i < 4; i++) if (y[i]) pr = pr ^ (8'(x) << i);
    for (int i = 7; i >= mm; i--) begin
      if (pr[i]) begin
        pl = 8'(pp) << (i - mm);
        pr = pr ^ pl;
      end
    end
    return pr[3:0];
  endfunction

  function automatic logic [3:0] ref_inv(input int mm, input logic [4:0] pp, input logic [3:0] x);
    for (int c = 1; c < 16; c++) begin
      if (ref_mul(mm, pp, x, 4'(c)) == 4'd1) return 4'(c);
    end
    return 4'd0;
  endfunction

  always @(negedge clk) begin : monitor
    exp_t e;
    if (!rst && done) begin
      if (sb.size() == 0) begin
        n_vec++;
        n_bad++;
        $display("FAIL spurious_done: got done=1 expected no pending result (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("inv", 32'(inv), 32'(e.inv));
        check("err", 32'(err), 32'(e.err));
        check("done_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  // Called at a negedge with the DUT idle; start is sampled on the next edge.
  task automatic issue(input logic [2:0] mm, input logic [4:0] pp, input logic [3:0] aa,
                       input logic [3:0] ei, input logic ee);
    exp_t e;
    m = mm; p = pp; a = aa; start = 1'b1;
    e.inv = ei;
    e.err = ee;
    e.at  = cyc + 1 + (ee ? 0 : 2 * int'(mm) - 2);
    sb.push_back(e);
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done();
    for (int k = 0; k < 40 && !done; k++) @(negedge clk);
    if (!done) begin
      n_vec++;
      n_bad++;
      $display("FAIL wait_done: got no done expected done within 40 cycles");
    end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 60 && (sb.size() != 0 || busy); k++) @(negedge clk);
    if (sb.size() != 0 || busy) begin
      n_vec++;
      n_bad++;
      $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
      sb.delete();
    end
  endtask

  logic [3:0] b2b_a [3] = '{4'd3, 4'd1, 4'd7};
  logic [3:0] b2b_e [3] = '{4'd6, 4'd1, 4'd4};
  logic [3:0] m2_e  [4] = '{4'd0, 4'd1, 4'd3, 4'd2};

  initial begin
    int bc;
    rst = 1'b0;
    #1 rst = 1'b1;
    #1;
    check("rst_busy", 32'(busy), 0);
    check("rst_done", 32'(done), 0);
    check("rst_inv",  32'(inv),  0);
    check("rst_err",  32'(err),  0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // x^3+x+1: inverse of x is x^2+1; busy spans 4 cycles.
    issue(3'd3, POLY_M3, 4'd2, 4'd5, 1'b0);
    bc = 0;
    for (int k = 0; k < 40; k++) begin
      if (done) break;
      if (busy) bc++;
      @(negedge clk);
    end
    check("busy_cycles", 32'(bc), 4);
    check("busy_at_done", 32'(busy), 0);

    // Back-to-back: each new start presented in the previous done cycle.
    for (int i = 0; i < 3; i++) begin
      issue(3'd3, POLY_M3, b2b_a[i], b2b_e[i], 1'b0);
      if (i < 2) wait_done();
    end
    wait_drain();

    // Bits above m are ignored: 0xA masked to 2 in GF(8).
    issue(3'd3, POLY_M3, 4'hA, 4'd5, 1'b0);
    wait_drain();

    // x^4+x^3+1: inverse of x is x^3+x^2.
    issue(3'd4, POLY_M4, 4'd2, 4'hC, 1'b0);
    wait_drain();
    for (int aa = 1; aa < 16; aa++) begin
      issue(3'd4, POLY_M4, 4'(aa), ref_inv(4, POLY_M4, 4'(aa)), 1'b0);
      wait_drain();
      check("a_times_inv", 32'(ref_mul(4, POLY_M4, 4'(aa), inv)), 1);
    end

    // GF(4), x^2+x+1: single SQ/MUL pair.
    for (int aa = 1; aa < 4; aa++) begin
      issue(3'd2, 5'b00111, 4'(aa), m2_e[aa], 1'b0);
      wait_drain();
    end

    // Error cases: zero operand, masked-to-zero operand, illegal m.
    issue(3'd3, POLY_M3, 4'd0, 4'd0, 1'b1);
    check("err_busy_a0", 32'(busy), 0);
    wait_drain();
    issue(3'd3, POLY_M3, 4'd8, 4'd0, 1'b1);
    check("err_busy_a8", 32'(busy), 0);
    wait_drain();
    issue(3'd5, POLY_M3, 4'd3, 4'd0, 1'b1);
    check("err_busy_m5", 32'(busy), 0);
    wait_drain();
    issue(3'd1, 5'b00011, 4'd1, 4'd0, 1'b1);
    wait_drain();

    // Starts while busy are dropped; the original operand's result comes out.
    issue(3'd3, POLY_M3, 4'd3, 4'd6, 1'b0);
    a = 4'd7; start = 1'b1;
    @(negedge clk);
    a = 4'd1;
    @(negedge clk);
    start = 1'b0;
    wait_drain();

    // Asynchronous reset while in MUL: outputs clear at once, no done.
    issue(3'd4, POLY_M4, 4'd5, 4'd0, 1'b0);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    check("arst_busy", 32'(busy), 0);
    check("arst_done", 32'(done), 0);
    check("arst_inv",  32'(inv),  0);
    check("arst_err",  32'(err),  0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("post_rst_busy", 32'(busy), 0);
    issue(3'd4, POLY_M4, 4'd5, ref_inv(4, POLY_M4, 4'd5), 1'b0);
    wait_drain();
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
